// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: instruction fields,
// the fetch FSM encoding and the HLT opcode check.
package cpu_pkg;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;

  localparam logic [3:0]         OP_HLT       = 4'hF;
  localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetchState_e;

  function automatic logic isHlt(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB] == OP_HLT;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer that catches a returned instruction while decode is
// stalled. Clear wins over load, and load wins over drain.
module fetch_skid
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] loadInstr,
  input  logic [INSTR_W-1:0] loadPcPlus2,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] pcPlus2,
  output logic               valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr   <= BUBBLE_INSTR;
      pcPlus2 <= '0;
      valid   <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      instr   <= loadInstr;
      pcPlus2 <= loadPcPlus2;
      valid   <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a
// req/ready handshake and fills the IF/ID register (with a one-entry skid).
//
// state | meaning
// BOOT  | first cycle after reset, no request issued
// RUN   | fetching normally
// HALT  | HLT delivered to IF/ID, fetch stopped until a redirect
module fetch_stage
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [INSTR_W-1:0] ifid_pc_plus2,
  output logic               ifid_valid,
  output logic               halted
);

  fetchState_e        state;
  fetchState_e        stateNext;
  logic [INSTR_W-1:0] pc;
  logic [INSTR_W-1:0] pcPlus2;
  logic [INSTR_W-1:0] reqAddr;
  logic               squash;

  logic               skidValid;
  logic [INSTR_W-1:0] skidInstr;
  logic [INSTR_W-1:0] skidPcPlus2;

  logic accept;
  logic acceptLive;
  logic deliverNew;
  logic deliverSkid;
  logic skidLoad;
  logic haltDeliver;

  assign pcPlus2 = pc + 16'd2;

  // While a squashed request is outstanding, pc already holds the redirect
  // target, so the old address is replayed from reqAddr.
  assign imem_addr = squash ? reqAddr : pc;

  assign accept      = imem_req & imem_ready;
  assign acceptLive  = accept & ~squash;
  assign deliverNew  = acceptLive & ~stall & ~redirect;
  assign deliverSkid = skidValid & ~stall & ~redirect;
  assign skidLoad    = acceptLive & stall & ~redirect;
  assign haltDeliver = (deliverNew & isHlt(imem_data)) |
                       (deliverSkid & isHlt(skidInstr));

  fetch_skid uSkid (
    .clk        (clk),
    .rst        (rst),
    .load       (skidLoad),
    .drain      (deliverSkid),
    .clear      (redirect),
    .loadInstr  (imem_data),
    .loadPcPlus2(pcPlus2),
    .instr      (skidInstr),
    .pcPlus2    (skidPcPlus2),
    .valid      (skidValid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      BOOT: stateNext = RUN;
      RUN: begin
        if (redirect) begin
          stateNext = RUN;
        end else if (haltDeliver) begin
          stateNext = HALT;
        end
      end
      HALT: begin
        if (redirect) begin
          stateNext = RUN;
        end
      end
      default: stateNext = BOOT;
    endcase
  end

  always_comb begin
    imem_req = (state == RUN) & ~skidValid;
    halted   = (state == HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= '0;
      reqAddr       <= '0;
      squash        <= 1'b0;
      ifid_instr    <= BUBBLE_INSTR;
      ifid_pc_plus2 <= '0;
      ifid_valid    <= 1'b0;
    end else begin
      reqAddr <= imem_addr;
      if (redirect) begin
        pc         <= {redirect_pc[INSTR_W-1:1], 1'b0};
        squash     <= imem_req & ~imem_ready;
        ifid_instr <= BUBBLE_INSTR;
        ifid_valid <= 1'b0;
      end else begin
        if (accept & squash) begin
          squash <= 1'b0;
        end
        if (acceptLive) begin
          pc <= pcPlus2;
        end
        if (deliverNew) begin
          ifid_instr    <= imem_data;
          ifid_pc_plus2 <= pcPlus2;
          ifid_valid    <= 1'b1;
        end else if (deliverSkid) begin
          ifid_instr    <= skidInstr;
          ifid_pc_plus2 <= skidPcPlus2;
          ifid_valid    <= 1'b1;
        end else if (!stall) begin
          ifid_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns addr^0x1000, except one
// programmable address that returns a HLT word.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;

  logic [15:0] hltAddr;
  int          checks;
  int          failures;

  assign imem_data = (imem_addr == hltAddr) ? 16'hF000 : (imem_addr ^ 16'h1000);

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_data    (imem_data),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus2(ifid_pc_plus2),
    .ifid_valid   (ifid_valid),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Redirect with ready high so any live request is consumed, not squashed.
  task automatic doRedirect(input logic [15:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    imem_ready  = 1'b1;
    tick();
    redirect   = 1'b0;
    imem_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", imem_addr); end
    checks++; if (ifid_instr !== 16'h0000) begin failures++; $display("FAIL reset_instr got=%h exp=0000", ifid_instr); end
    checks++; if (ifid_pc_plus2 !== 16'h0000) begin failures++; $display("FAIL reset_pcp2 got=%h exp=0000", ifid_pc_plus2); end
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    rst = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin failures++; $display("FAIL first_req got=%b/%h exp=1/0000", imem_req, imem_addr); end
  endtask

  task automatic test_streaming;
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_addr !== 16'(2*i) || imem_req !== 1'b1) begin failures++; $display("FAIL stream_addr%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, 16'(2*i)); end
      tick();
      checks++; if (ifid_pc_plus2 !== 16'(2*i+2) || ifid_valid !== 1'b1) begin failures++; $display("FAIL stream_pcp2_%0d got=%h/%b exp=%h/1", i, ifid_pc_plus2, ifid_valid, 16'(2*i+2)); end
      checks++; if (ifid_instr !== (16'(2*i) ^ 16'h1000)) begin failures++; $display("FAIL stream_instr%0d got=%h exp=%h", i, ifid_instr, 16'(2*i) ^ 16'h1000); end
    end
    imem_ready = 1'b0;
  endtask

  task automatic test_skid;
    doRedirect(16'h0100);
    tick();
    tick();
    stall = 1'b1;
    imem_ready = 1'b1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin failures++; $display("FAIL skid_req_before got=%b/%h exp=1/0100", imem_req, imem_addr); end
    tick();
    imem_ready = 1'b0;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL skid_req_full got=%b exp=0", imem_req); end
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL skid_valid_held got=%b exp=0", ifid_valid); end
    tick();
    checks++; if (imem_req !== 1'b0 || ifid_valid !== 1'b0) begin failures++; $display("FAIL skid_still_full got=%b/%b exp=0/0", imem_req, ifid_valid); end
    stall = 1'b0;
    tick();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 16'h1100 || ifid_pc_plus2 !== 16'h0102) begin failures++; $display("FAIL skid_drain got=%b/%h/%h exp=1/1100/0102", ifid_valid, ifid_instr, ifid_pc_plus2); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0102) begin failures++; $display("FAIL skid_next_req got=%b/%h exp=1/0102", imem_req, imem_addr); end
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    checks++; if (ifid_instr !== 16'h1102 || ifid_pc_plus2 !== 16'h0104) begin failures++; $display("FAIL skid_no_dup got=%h/%h exp=1102/0104", ifid_instr, ifid_pc_plus2); end
  endtask

  task automatic test_redirect_squash;
    doRedirect(16'h0010);
    tick();
    redirect    = 1'b1;
    redirect_pc = 16'h0041;
    tick();
    redirect = 1'b0;
    checks++; if (imem_addr !== 16'h0010 || imem_req !== 1'b1) begin failures++; $display("FAIL squash_addr_hold got=%b/%h exp=1/0010", imem_req, imem_addr); end
    tick();
    checks++; if (imem_addr !== 16'h0010) begin failures++; $display("FAIL squash_addr_hold2 got=%h exp=0010", imem_addr); end
    imem_ready = 1'b1;
    tick();
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL squash_discard got=%b exp=0", ifid_valid); end
    checks++; if (imem_addr !== 16'h0040 || imem_req !== 1'b1) begin failures++; $display("FAIL squash_target got=%b/%h exp=1/0040", imem_req, imem_addr); end
    tick();
    imem_ready = 1'b0;
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 16'h1040 || ifid_pc_plus2 !== 16'h0042) begin failures++; $display("FAIL squash_first got=%b/%h/%h exp=1/1040/0042", ifid_valid, ifid_instr, ifid_pc_plus2); end
  endtask

  task automatic test_halt;
    hltAddr = 16'h0006;
    doRedirect(16'h0004);
    imem_ready = 1'b1;
    tick();
    checks++; if (ifid_pc_plus2 !== 16'h0006 || imem_addr !== 16'h0006) begin failures++; $display("FAIL halt_pre got=%h/%h exp=0006/0006", ifid_pc_plus2, imem_addr); end
    tick();
    checks++; if (ifid_instr !== 16'hF000 || ifid_valid !== 1'b1) begin failures++; $display("FAIL halt_ifid got=%h/%b exp=f000/1", ifid_instr, ifid_valid); end
    checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL halt_state got=%b/%b exp=1/0", halted, imem_req); end
    tick();
    checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || ifid_valid !== 1'b0) begin failures++; $display("FAIL halt_hold got=%b/%b/%b exp=1/0/0", halted, imem_req, ifid_valid); end
    imem_ready = 1'b0;
    doRedirect(16'h0020);
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0020) begin failures++; $display("FAIL halt_exit got=%b/%b/%h exp=0/1/0020", halted, imem_req, imem_addr); end
  endtask

  task automatic test_redirect_priority;
    doRedirect(16'h0200);
    imem_ready = 1'b1;
    tick();
    stall = 1'b1;
    tick();
    checks++; if (ifid_valid !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL prio_skid_full got=%b/%b exp=1/0", ifid_valid, imem_req); end
    imem_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h0300;
    tick();
    redirect = 1'b0;
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 16'h0000) begin failures++; $display("FAIL prio_bubble got=%b/%h exp=0/0000", ifid_valid, ifid_instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0300 || halted !== 1'b0) begin failures++; $display("FAIL prio_target got=%b/%h/%b exp=1/0300/0", imem_req, imem_addr, halted); end
    stall = 1'b0;
    tick();
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL prio_skid_cleared got=%b exp=0", ifid_valid); end
    hltAddr = 16'h0006;
    doRedirect(16'h0006);
    redirect    = 1'b1;
    redirect_pc = 16'h0050;
    imem_ready  = 1'b1;
    tick();
    redirect   = 1'b0;
    imem_ready = 1'b0;
    hltAddr    = 16'hFFFF;
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 16'h0000 || halted !== 1'b0) begin failures++; $display("FAIL hlt_redirect got=%b/%h/%b exp=0/0000/0", ifid_valid, ifid_instr, halted); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0050) begin failures++; $display("FAIL hlt_redirect_req got=%b/%h exp=1/0050", imem_req, imem_addr); end
  endtask

  task automatic test_wrap;
    doRedirect(16'hFFFE);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    checks++; if (ifid_pc_plus2 !== 16'h0000 || ifid_instr !== 16'hEFFE) begin failures++; $display("FAIL wrap_ifid got=%h/%h exp=0000/effe", ifid_pc_plus2, ifid_instr); end
    checks++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin failures++; $display("FAIL wrap_addr got=%b/%h exp=1/0000", imem_req, imem_addr); end
  endtask

  task automatic test_reset_midwait;
    doRedirect(16'h0080);
    tick();
    rst = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin failures++; $display("FAIL rst_mid_req got=%b/%h exp=0/0000", imem_req, imem_addr); end
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 16'h0000 || ifid_pc_plus2 !== 16'h0000 || halted !== 1'b0) begin failures++; $display("FAIL rst_mid_ifid got=%b/%h/%h/%b exp=0/0000/0000/0", ifid_valid, ifid_instr, ifid_pc_plus2, halted); end
    rst = 1'b0;
    imem_ready = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || ifid_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_stale got=%b/%h/%b exp=1/0000/0", imem_req, imem_addr, ifid_valid); end
    tick();
    imem_ready = 1'b0;
    checks++; if (ifid_pc_plus2 !== 16'h0002 || ifid_instr !== 16'h1000 || ifid_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_restart got=%h/%h/%b exp=0002/1000/1", ifid_pc_plus2, ifid_instr, ifid_valid); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    hltAddr     = 16'hFFFF;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    imem_ready  = 1'b0;
    test_reset();
    test_streaming();
    test_skid();
    test_redirect_squash();
    test_halt();
    test_redirect_priority();
    test_wrap();
    test_reset_midwait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
